reg_access_arbiter: RTL and testbench
=====================================

# reg_access_arbiter

Round-robin access arbiter and sequencer sitting in front of the `register_block` register file. It accepts single-word read/write requests from `NREQ` requesters over a valid/ready handshake and grants one at a time. It drives the register file's write/read ports for exactly one cycle per transaction and returns a one-cycle response pulse with read data and an error flag to the granted requester.

## Interface
- `WIDTH`, 16: data width; matches the register file.
- `DEPTH`, 32: number of registers; `AW = $clog2(DEPTH)`.
- `NREQ`, 2: number of requesters, 2..8.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `i_req_valid`  in  NREQ  per-requester request valid
- `o_req_ready`  out  NREQ  one-hot acceptance; a transfer occurs when valid&&ready
- `i_req_write`  in  NREQ  1 = write, 0 = read
- `i_req_addr`  in  NREQ*AW  packed addresses; requester k at [k*AW +: AW]
- `i_req_wdata`  in  NREQ*WIDTH  packed write data
- `o_rsp_valid`  out  NREQ  one-hot, one-cycle response pulse
- `o_rsp_rdata`  out  WIDTH  read data, valid with `o_rsp_valid`
- `o_rsp_err`  out  1  error flag, valid with `o_rsp_valid`
- `o_w_en`, `o_w_addr`, `o_w_value`  out  1/AW/WIDTH  register file write port
- `o_r_en`, `o_r_addr`  out  1/AW  register file read port
- `i_r_value`  in  WIDTH  register file read data (1-cycle read latency)

## Operation
- FSM states:
  - Reads: IDLE → ISSUE → WAIT → RESP → IDLE.
  - Writes and errored requests: IDLE → ISSUE → RESP → IDLE.
- IDLE:
  - `o_req_ready` is combinational: one-hot grant from the round-robin pick among `i_req_valid`, gated by state==IDLE.
  - On a transfer, latch index, op, addr and wdata.
  - Advance the RR pointer to grant index+1 (mod NREQ).
  - No valid requests: stay in IDLE; all ready bits 0.
- ISSUE:
  - Assert exactly one of `o_w_en`/`o_r_en` for this one cycle, with the latched addr/data.
  - Address >= DEPTH: assert neither enable; set err and go to RESP.
- WAIT: capture `i_r_value` into the rdata register.
- RESP:
  - Pulse `o_rsp_valid[idx]` for one cycle.
  - Reads drive `o_rsp_rdata` with the captured data; writes and errors drive 0.
- Requesters may drop or change `i_req_valid` while not granted; nothing is captured without a transfer.
- There is no response back-pressure; requesters must sample the pulse.
- Round-robin guarantees each continuously-valid requester a grant within NREQ transactions.

## Timing
- All outputs except `o_req_ready` are registered.
- Reset values: state IDLE, RR pointer 0, and all outputs 0.
- Async reset mid-transaction:
  - Aborts immediately; no response is issued.
  - `o_w_en`/`o_r_en` drop asynchronously.
- Write latency: transfer at T, `o_w_en` at T+1, `o_rsp_valid` at T+2, next ready possible at T+3.
- Read latency: transfer at T, `o_r_en` at T+1, capture at T+2, `o_rsp_valid` at T+3, next ready possible at T+4.
- Error latency: transfer at T, `o_rsp_valid` with `o_rsp_err`=1 at T+2.
- Simultaneous valids: the winner is the first index at or after the RR pointer.

## Configuration
- `REG_ARB_WRITE_PROTECT_EN`:
  - Defined: a write to address 0 (ID register) is not issued (`o_w_en` stays 0). The response is returned at T+2 with `o_rsp_err`=1. Reads of address 0 are unaffected.
  - Undefined: address 0 is writable like any other register.

## Structure
- Package `reg_arb_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, WAIT, RESP);
  - `ADDR_ID` = 0;
  - the write-protect error code constant.
- Sub-module `rr_picker`: combinational NREQ-wide round-robin one-hot selector taking the request vector and pointer.
- The top holds the FSM, latches and register-file drive.

## Test plan
- Reset, then requester 0 writes 0x1234 to address 5:
  - `o_w_en`=1 with addr 5 at T+1;
  - `o_rsp_valid`=01 at T+2 with err 0.
- Requester 1 reads address 5 after the above:
  - `o_r_en` at T+1;
  - `o_rsp_valid`=10 at T+3 with `o_rsp_rdata`=0x1234.
- Both requesters hold valid continuously for 6 transactions: grants alternate 0,1,0,1,0,1, and no requester is starved.
- Read of address DEPTH with DEPTH=24: no enable pulses; `o_rsp_err`=1 and rdata 0 at T+2.
- With `REG_ARB_WRITE_PROTECT_EN`, write 0xFFFF to address 0: no `o_w_en`; err=1; a subsequent read returns 0xb00.
- Assert `reset` in the WAIT state: no `o_rsp_valid`; outputs 0; the first post-reset request is granted to requester 0.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int   ADDR_ID           = 0;
  localparam logic ERR_WRITE_PROTECT = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin one-hot selector: the first asserted request at or
// after ptr wins.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);

  int k;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    k     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = PW'(k);
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter/sequencer in front of register_block; one transaction at a time.
// Optional REG_ARB_WRITE_PROTECT_EN rejects writes to the ID register (address 0).
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int NREQ  = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ-1:0]       i_req_write,
  input  logic [NREQ*AW-1:0]    i_req_addr,
  input  logic [NREQ*WIDTH-1:0] i_req_wdata,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]      o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_w_en,
  output logic [AW-1:0]         o_w_addr,
  output logic [WIDTH-1:0]      o_w_value,
  output logic                  o_r_en,
  output logic [AW-1:0]         o_r_addr,
  input  logic [WIDTH-1:0]      i_r_value
);

  localparam int PW = $clog2(NREQ);

  arb_state_t      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   idx_q;
  logic            write_q;
  logic            err_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   pick_idx;
  logic            xfer;
  logic            sel_write;
  logic [AW-1:0]   sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic            range_err;
  logic            protect;
  logic            sel_err;

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (pick_idx)
  );

  assign o_req_ready = (state == IDLE) ? grant : '0;
  assign xfer        = |(i_req_valid & o_req_ready);
  assign sel_write   = i_req_write[pick_idx];
  assign sel_addr    = i_req_addr[pick_idx*AW +: AW];
  assign sel_wdata   = i_req_wdata[pick_idx*WIDTH +: WIDTH];
  assign range_err   = ({1'b0, sel_addr} >= (AW+1)'(DEPTH));

`ifdef REG_ARB_WRITE_PROTECT_EN
  assign protect = sel_write && (sel_addr == AW'(ADDR_ID));
`else
  assign protect = 1'b0;
`endif

  assign sel_err = range_err | (protect ? ERR_WRITE_PROTECT : 1'b0);

  // Enables are registered at the transfer edge so they are high only in ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      o_w_en      <= 1'b0;
      o_r_en      <= 1'b0;
      o_w_addr    <= '0;
      o_w_value   <= '0;
      o_r_addr    <= '0;
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_rsp_valid <= '0;
          o_rsp_rdata <= '0;
          o_rsp_err   <= 1'b0;
          if (xfer) begin
            idx_q     <= pick_idx;
            write_q   <= sel_write;
            err_q     <= sel_err;
            ptr       <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
            o_w_en    <= sel_write && !sel_err;
            o_r_en    <= !sel_write && !sel_err;
            o_w_addr  <= sel_addr;
            o_w_value <= sel_wdata;
            o_r_addr  <= sel_addr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          o_w_en <= 1'b0;
          o_r_en <= 1'b0;
          if (write_q || err_q) begin
            o_rsp_valid <= NREQ'(1) << idx_q;
            o_rsp_rdata <= '0;
            o_rsp_err   <= err_q;
            state       <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          o_rsp_valid <= NREQ'(1) << idx_q;
          o_rsp_rdata <= i_r_value;
          o_rsp_err   <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          o_rsp_valid <= '0;
          o_rsp_rdata <= '0;
          o_rsp_err   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter (DEPTH=24, NREQ=2) with a behavioural register file.
module tb_reg_access_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 24;
  localparam int NREQ  = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_write = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  rsp_err;
  logic                  w_en;
  logic [AW-1:0]         w_addr;
  logic [WIDTH-1:0]      w_value;
  logic                  r_en;
  logic [AW-1:0]         r_addr;
  logic [WIDTH-1:0]      r_value = '0;

  logic [WIDTH-1:0] mem [0:31] = '{0: 16'h0b00, default: 16'h0000};

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_w_en      (w_en),
    .o_w_addr    (w_addr),
    .o_w_value   (w_value),
    .o_r_en      (r_en),
    .o_r_addr    (r_addr),
    .i_r_value   (r_value)
  );

  // Register file stand-in: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_value;
    if (r_en) r_value <= mem[r_addr];
  end

  typedef struct {
    int          idx;
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        exp_wen;
    logic        exp_ren;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int rsp_at = 0, wen_at = 0, ren_at = 0, rsp_cnt = 0;
    logic [NREQ-1:0] rv = '0;
    logic [15:0] rd = '0, wv = '0;
    logic err = 1'b0;
    logic [4:0] ea = '0;
    @(negedge clk);
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    req_write[v.idx] = v.wr;
    req_addr[v.idx*AW +: AW] = v.addr;
    req_wdata[v.idx*WIDTH +: WIDTH] = v.wdata;
    #1 check("ready", 32'(req_ready), 32'(1) << v.idx);
    @(posedge clk);
    #1 req_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (w_en && wen_at == 0) begin wen_at = c; ea = w_addr; wv = w_value; end
      if (r_en && ren_at == 0) begin ren_at = c; ea = r_addr; end
      if (|rsp_valid) begin
        rsp_cnt++;
        if (rsp_at == 0) begin rsp_at = c; rv = rsp_valid; rd = rsp_rdata; err = rsp_err; end
      end
    end
    check("rsp_latency", 32'(rsp_at), 32'(v.exp_lat));
    check("rsp_pulses", 32'(rsp_cnt), 32'd1);
    check("rsp_valid", 32'(rv), 32'(1) << v.idx);
    check("rsp_err", 32'(err), 32'(v.exp_err));
    check("rsp_rdata", 32'(rd), 32'(v.exp_rdata));
    check("w_en_cycle", 32'(wen_at), v.exp_wen ? 32'd1 : 32'd0);
    check("r_en_cycle", 32'(ren_at), v.exp_ren ? 32'd1 : 32'd0);
    if (v.exp_wen || v.exp_ren) check("en_addr", 32'(ea), 32'(v.addr));
    if (v.exp_wen) check("w_value", 32'(wv), 32'(v.wdata));
  endtask

  initial begin
    int got;
    int rsp_seen;
    vec_t rd5;

    //        idx wr  addr   wdata      wen   ren   err   rdata     lat
    vecs[0] = '{0, 1'b1, 5'd5,  16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 2};
    vecs[1] = '{1, 1'b0, 5'd5,  16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 3};
    vecs[2] = '{0, 1'b0, 5'd24, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 2};
    vecs[3] = '{1, 1'b1, 5'd23, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 2};
    vecs[4] = '{0, 1'b0, 5'd23, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hBEEF, 3};
    vecs[5] = '{1, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 16'h0b00, 3};
`ifdef REG_ARB_WRITE_PROTECT_EN
    vecs[6] = '{0, 1'b1, 5'd0,  16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000, 2};
    vecs[7] = '{1, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 16'h0b00, 3};
`else
    vecs[6] = '{0, 1'b1, 5'd0,  16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 2};
    vecs[7] = '{1, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 3};
`endif
    vecs[8] = '{0, 1'b0, 5'd31, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 2};
    rd5     = '{0, 1'b0, 5'd5,  16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 3};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_outputs", {16'(rsp_valid), 16'(rsp_rdata)}, 32'd0);
    check("reset_ctrl", {28'd0, rsp_err, w_en, r_en, |w_addr}, 32'd0);

    // Both requesters continuously valid: grants must alternate from requester 0.
    @(negedge clk);
    req_write = '0;
    req_addr  = {5'd2, 5'd1};
    req_valid = 2'b11;
    for (int g = 0; g < 6; g++) begin
      got = -1;
      for (int c = 0; c < 20 && got < 0; c++) begin
        #1;
        if (|req_ready) got = int'(req_ready);
        else @(negedge clk);
      end
      check("rr_grant", 32'(got), (g % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    req_valid = '0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Reset while waiting on read data: no response, pointer back to 0.
    @(negedge clk);
    req_valid = 2'b01;
    req_write[0] = 1'b0;
    req_addr[0 +: AW] = 5'd5;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("abort_r_en_issue", 32'(r_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_r_en_drop", 32'(r_en), 32'd0);
    check("abort_outputs", {16'(rsp_valid), 16'(rsp_rdata)}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (|rsp_valid) rsp_seen++;
    end
    check("abort_no_rsp", 32'(rsp_seen), 32'd0);
    req_valid = 2'b11;
    #1 check("post_reset_grant", 32'(req_ready), 32'd1);
    req_valid = '0;
    run_txn(rd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
